// File: rtl/switch_pkg.sv
// Shared types for the 4-port switch: packet classes, the buffered packet
// record and a small one-hot helper.
package switch_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int PKT_DATA_W = 8;

  typedef enum logic [1:0] {
    SDP = 2'd0,
    MDP = 2'd1,
    BDP = 2'd2,
    ERR = 2'd3
  } p_type;

  typedef struct packed {
    logic [NUM_PORTS-1:0]  source;
    logic [NUM_PORTS-1:0]  target;
    logic [PKT_DATA_W-1:0] data;
    p_type                 ptype;
  } packet_t;

  function automatic logic is_onehot(input logic [NUM_PORTS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/ingress_port_if.sv
// Upstream and fabric-side handshakes of one ingress port.
// Valid/ready: a beat transfers on a rising edge where valid and ready are both
// high; the sender holds its payload stable while valid=1 and ready=0.
interface ingress_port_if #(
  parameter int DATA_W = 8
) ();
  import switch_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_PORTS-1:0] in_source;
  logic [NUM_PORTS-1:0] in_target;
  logic [DATA_W-1:0]    in_data;

  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_PORTS-1:0] out_source;
  logic [NUM_PORTS-1:0] out_target;
  logic [DATA_W-1:0]    out_data;
  p_type                out_type;

  // master = upstream producer plus fabric consumer; slave = the ingress port
  modport master (
    output in_valid, in_source, in_target, in_data, out_ready,
    input  in_ready, out_valid, out_source, out_target, out_data, out_type
  );

  modport slave (
    input  in_valid, in_source, in_target, in_data, out_ready,
    output in_ready, out_valid, out_source, out_target, out_data, out_type
  );

endinterface

// File: rtl/ingress_port_parser.sv
// Combinational packet classifier: legality check and SDP/MDP/BDP tagging.
module ingress_port_parser
  import switch_pkg::*;
(
  input  logic [NUM_PORTS-1:0] source,
  input  logic [NUM_PORTS-1:0] target,
  output logic                 pkt_valid,
  output p_type                pkt_type
);

  logic legal;

  // Broadcast is the one target allowed to include the source port.
  assign legal = is_onehot(source) && (target != '0) &&
                 (((target & source) == '0) || (target == '1));

  always_comb begin
    pkt_valid = 1'b0;
    pkt_type  = ERR;
    if (legal) begin
      pkt_valid = 1'b1;
      if (target == '1)
        pkt_type = BDP;
      else if (is_onehot(target))
        pkt_type = SDP;
      else
        pkt_type = MDP;
    end
  end

endmodule

// File: rtl/ingress_port.sv
// Ingress stage: classify incoming packets, drop and count illegal ones, and
// buffer legal ones in a first-word-fall-through FIFO toward the fabric.
module ingress_port
  import switch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  ingress_port_if.slave          bus,
  output logic                   drop_pulse,
  output logic [CNT_W-1:0]       drop_count,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  typedef struct packed {
    logic [NUM_PORTS-1:0] source;
    logic [NUM_PORTS-1:0] target;
    logic [DATA_W-1:0]    data;
    p_type                ptype;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               pkt_valid;
  p_type              pkt_type;
  logic               accept;
  logic               push;
  logic               drop;
  logic               pop;

  ingress_port_parser u_parser (
    .source    (bus.in_source),
    .target    (bus.in_target),
    .pkt_valid (pkt_valid),
    .pkt_type  (pkt_type)
  );

  // Both ready and valid come from occupancy alone, so neither side sees a
  // combinational path from the other's handshake.
  assign bus.in_ready  = (occupancy != FULL_OCC);
  assign bus.out_valid = (occupancy != '0);

  assign accept = bus.in_valid & bus.in_ready;
  assign push   = accept & pkt_valid;
  assign drop   = accept & ~pkt_valid;
  assign pop    = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      drop_pulse <= 1'b0;
      drop_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{source: bus.in_source, target: bus.in_target,
                         data: bus.in_data, ptype: pkt_type};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      drop_pulse <= drop;
      if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

  // Stale entries behind rd_ptr stay in storage, so the head is masked when empty.
  always_comb begin
    bus.out_source = '0;
    bus.out_target = '0;
    bus.out_data   = '0;
    bus.out_type   = ERR;
    if (bus.out_valid) begin
      bus.out_source = mem[rd_ptr].source;
      bus.out_target = mem[rd_ptr].target;
      bus.out_data   = mem[rd_ptr].data;
      bus.out_type   = mem[rd_ptr].ptype;
    end
  end

endmodule

// File: tb/tb_ingress_port.sv
// Bench for ingress_port (DEPTH=4, DATA_W=8): queue-based reference model,
// per-cycle compare process and directed scenarios with literal expectations.
module tb_ingress_port;
  import switch_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       drop_pulse;
  logic [7:0] drop_count;
  logic [2:0] occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  ingress_port_if #(.DATA_W(8)) ifc ();

  ingress_port #(.DATA_W(8), .DEPTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (ifc.slave),
    .drop_pulse (drop_pulse),
    .drop_count (drop_count),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  packet_t exp_q[$];
  int      m_drops = 0;
  bit      m_pulse = 0;
  bit      m_acc, m_pop, m_legal;
  p_type   m_ty;
  packet_t m_pkt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void classify(input logic [3:0] s, input logic [3:0] t,
                                   output bit legal, output p_type ty);
    int ns = 0;
    int nt = 0;
    for (int i = 0; i < 4; i++) begin
      ns += int'(s[i]);
      nt += int'(t[i]);
    end
    legal = (ns == 1) && (nt > 0) && (((s & t) == 4'h0) || (t == 4'hf));
    ty = ERR;
    if (legal) ty = (t == 4'hf) ? BDP : ((nt == 1) ? SDP : MDP);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_drops = 0;
      m_pulse = 0;
    end else begin
      m_acc   = ifc.in_valid && (exp_q.size() != 4);
      m_pop   = (exp_q.size() != 0) && ifc.out_ready;
      m_pulse = 0;
      m_legal = 0;
      if (m_acc) begin
        classify(ifc.in_source, ifc.in_target, m_legal, m_ty);
        if (!m_legal) begin
          m_pulse = 1;
          if (m_drops < 255) m_drops++;
        end
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_acc && m_legal) begin
        m_pkt.source = ifc.in_source;
        m_pkt.target = ifc.in_target;
        m_pkt.data   = ifc.in_data;
        m_pkt.ptype  = m_ty;
        exp_q.push_back(m_pkt);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("occupancy", occupancy, exp_q.size());
      chk("in_ready", ifc.in_ready, exp_q.size() != 4);
      chk("out_valid", ifc.out_valid, exp_q.size() != 0);
      chk("drop_pulse", drop_pulse, m_pulse);
      chk("drop_count", drop_count, m_drops);
      if (exp_q.size() != 0) begin
        chk("out_source", ifc.out_source, exp_q[0].source);
        chk("out_target", ifc.out_target, exp_q[0].target);
        chk("out_data", ifc.out_data, exp_q[0].data);
        chk("out_type", ifc.out_type, exp_q[0].ptype);
      end else begin
        chk("idle_source", ifc.out_source, 0);
        chk("idle_target", ifc.out_target, 0);
        chk("idle_data", ifc.out_data, 0);
        chk("idle_type", ifc.out_type, ERR);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered on a falling edge; returns on the falling edge after acceptance.
  task automatic send(input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
    int k = 0;
    ifc.in_valid  = 1'b1;
    ifc.in_source = s;
    ifc.in_target = t;
    ifc.in_data   = d;
    while (!ifc.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("send_timeout", ifc.in_ready, 1);
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    ifc.out_ready = 1'b1;
    while (occupancy != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("drain_empty", occupancy, 0);
    ifc.out_ready = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_source = '0;
    ifc.in_target = '0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("init_occ", occupancy, 0);
    chk("init_in_ready", ifc.in_ready, 1);

    // 1. reset in the middle of traffic
    send(4'b0001, 4'b0100, 8'h11);
    send(4'b0001, 4'b0000, 8'h00);
    send(4'b0010, 4'b0001, 8'h22);
    send(4'b0100, 4'b1000, 8'h33);
    chk("t1_occ_before", occupancy, 3);
    chk("t1_drops_before", drop_count, 1);
    #3 rst = 1'b1;
    #1;
    chk("t1_occ_rst", occupancy, 0);
    chk("t1_valid_rst", ifc.out_valid, 0);
    chk("t1_count_rst", drop_count, 0);
    chk("t1_pulse_rst", drop_pulse, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t1_in_ready", ifc.in_ready, 1);

    // 2. single SDP
    send(4'b0001, 4'b0100, 8'hA5);
    chk("t2_valid", ifc.out_valid, 1);
    chk("t2_type", ifc.out_type, SDP);
    chk("t2_target", ifc.out_target, 4'b0100);
    chk("t2_data", ifc.out_data, 8'hA5);
    chk("t2_occ", occupancy, 1);

    // 3. classes and drops
    send(4'b0010, 4'b1111, 8'hB0);
    send(4'b0001, 4'b0110, 8'hB1);
    chk("t3_occ", occupancy, 3);
    chk("t3_head", ifc.out_data, 8'hA5);
    send(4'b0011, 4'b0100, 8'hC0);
    chk("t3_pulse1", drop_pulse, 1);
    send(4'b0001, 4'b0000, 8'hC1);
    chk("t3_pulse2", drop_pulse, 1);
    send(4'b0001, 4'b0011, 8'hC2);
    chk("t3_pulse3", drop_pulse, 1);
    chk("t3_count", drop_count, 3);
    chk("t3_occ_after", occupancy, 3);
    ifc.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_bdp", ifc.out_type, BDP);
    @(negedge clk);
    chk("t3_mdp", ifc.out_type, MDP);
    drain();

    // 4. full FIFO, fifth packet held, then in-order release
    fork
      begin
        for (int i = 0; i < 5; i++) send(4'b0001, 4'b0010, 8'h40 + 8'(i));
      end
      begin
        repeat (6) @(negedge clk);
        chk("t4_in_ready", ifc.in_ready, 0);
        chk("t4_occ", occupancy, 4);
        ifc.out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
          chk("t4_order", ifc.out_data, 8'h40 + 8'(j));
          @(negedge clk);
        end
      end
    join
    drain();

    // 5. steady push+pop at occupancy 2, across pointer wrap
    send(4'b0100, 4'b0001, 8'h60);
    send(4'b0100, 4'b0011, 8'h61);
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(4'b1000, 4'b0111, 8'h70 + 8'(i));
      if (i == 5) chk("t5_occ", occupancy, 2);
    end
    chk("t5_occ_end", occupancy, 2);
    chk("t5_head", ifc.out_data, 8'h7A);
    drain();

    // drop concurrent with pop
    send(4'b0001, 4'b0010, 8'h55);
    ifc.out_ready = 1'b1;
    send(4'b0001, 4'b0000, 8'h56);
    chk("dp_occ", occupancy, 0);
    chk("dp_pulse", drop_pulse, 1);
    chk("dp_count", drop_count, 4);
    ifc.out_ready = 1'b0;

    // 6. drop counter saturation
    for (int i = 0; i < 300; i++) begin
      send(4'b0011, 4'b0100, 8'(i));
      chk("t6_pulse", drop_pulse, 1);
    end
    chk("t6_count", drop_count, 255);
    repeat (3) @(negedge clk);
    chk("t6_count_hold", drop_count, 255);
    chk("t6_pulse_idle", drop_pulse, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
